gshare_branch_predictor: RTL

- Parametrised next-PC predictor for the 5-stage pipelined RV32I core. Replaces the fixed PC+4 next-PC path.
- IF looks up a tagged branch target buffer (BTB) plus a gshare pattern history table (PHT) in the same cycle and gets a predicted next PC.
- EX resolves branches and jumps, writes the outcome back, and receives a mispredict flag that drives the pipeline flush.
- Performance counters report prediction accuracy to the testbench.

---
 rtl/gshare_branch_predictor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - gshare next-PC predictor with tagged BTB and accuracy counters
// IF-stage lookup is purely combinational; EX-stage resolution writes BTB/PHT/GHR on the rising edge.
module gshare_branch_predictor #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 32,
  parameter int GHR_BITS = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   if_pc,
  output logic [ADDR_W-1:0]   pred_next_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [ADDR_W-1:0]   upd_pc,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [ADDR_W-1:0]   upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic [ADDR_W-1:0]   upd_pred_next_pc,
  output logic                mispredict,
  output logic [ADDR_W-1:0]   correct_pc,
  output logic [CNT_W-1:0]    cnt_updates,
  output logic [CNT_W-1:0]    cnt_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0]  btb_valid;
  logic [ENTRIES-1:0]  btb_jump;
  logic [TAG_W-1:0]    btb_tag    [ENTRIES];
  logic [ADDR_W-1:0]   btb_target [ENTRIES];
  logic [1:0]          pht        [ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] ghr_next;

  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  if_pht_idx;
  logic [IDX_W-1:0]  ghr_ext;
  logic [TAG_W-1:0]  if_tag;
  logic [ADDR_W-1:0] if_pc_inc;
  logic              btb_hit;

  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  upd_pht_idx;
  logic [IDX_W-1:0]  upd_ghr_ext;
  logic [TAG_W-1:0]  upd_tag;
  logic [ADDR_W-1:0] upd_pc_inc;
  logic [ADDR_W-1:0] actual_pc;
  logic [1:0]        pht_cur;
  logic [1:0]        pht_next;
  logic              ctl_valid;
  logic              is_branch;
  logic              is_jump;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  always_comb begin
    ghr_ext                      = '0;
    ghr_ext[GHR_BITS-1:0]        = ghr;
    upd_ghr_ext                  = '0;
    upd_ghr_ext[GHR_BITS-1:0]    = upd_ghr;
  end

  assign if_idx     = if_pc[IDX_W+1:2];
  assign if_tag     = if_pc[ADDR_W-1:IDX_W+2];
  assign if_pht_idx = if_idx ^ ghr_ext;
  assign if_pc_inc  = if_pc + ADDR_W'(4);

  assign btb_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pred_taken   = btb_hit && (btb_jump[if_idx] || pht[if_pht_idx][1]);
  assign pred_next_pc = pred_taken ? btb_target[if_idx] : if_pc_inc;
  assign pred_ghr     = ghr;

  // Both type flags high is resolved as a jump, so it never trains direction state.
  assign is_jump     = upd_is_jump;
  assign is_branch   = upd_is_branch && !upd_is_jump;
  assign ctl_valid   = upd_valid && (upd_is_branch || upd_is_jump) && !reset;

  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_pht_idx = upd_idx ^ upd_ghr_ext;
  assign upd_pc_inc  = upd_pc + ADDR_W'(4);
  assign actual_pc   = upd_taken ? upd_target : upd_pc_inc;

  assign correct_pc  = ctl_valid ? actual_pc : upd_pc_inc;
  assign mispredict  = ctl_valid && (actual_pc != upd_pred_next_pc);

  assign pht_cur = pht[upd_pht_idx];

  always_comb begin
    pht_next = pht_cur;
    if (upd_taken) begin
      if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
    end
  end

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_next = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr[GHR_BITS-2:0], upd_taken};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid       <= '0;
      ghr             <= '0;
      cnt_updates     <= '0;
      cnt_mispredicts <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (ctl_valid) begin
      // Only taken outcomes allocate, so a not-taken branch can never evict a live target.
      if (upd_taken) begin
        btb_valid[upd_idx] <= 1'b1;
      end
      if (is_branch) begin
        pht[upd_pht_idx] <= pht_next;
        ghr              <= ghr_next;
      end
      if (!(&cnt_updates)) begin
        cnt_updates <= cnt_updates + CNT_W'(1);
      end
      if (mispredict && !(&cnt_mispredicts)) begin
        cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
      end
    end
  end

  // Payload fields are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (ctl_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
      btb_jump[upd_idx]   <= is_jump;
    end
  end

endmodule
